// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO pointer controller.
// Pointers carry one extra wrap bit above the RAM address bits.
package fifo_pkg;

  localparam int unsigned FIFO_PTR_W_DEF = 4;
  // Widest pointer the compare helpers accept (address bits + wrap bit <= 16).
  localparam int unsigned FIFO_PTR_W_MAX = 15;
  localparam int unsigned FIFO_EXT_W     = FIFO_PTR_W_MAX + 1;

  typedef logic [FIFO_PTR_W_DEF:0] ptr_t;
  typedef logic [FIFO_PTR_W_DEF:0] cnt_t;

  // Full: wrap bits differ while the address bits match. Inputs are zero-extended pointers
  // whose wrap bit sits at index ptr_w.
  function automatic logic ptr_full(input logic [FIFO_EXT_W-1:0] wr_ptr,
                                    input logic [FIFO_EXT_W-1:0] rd_ptr,
                                    input logic [3:0]            ptr_w);
    logic [FIFO_EXT_W-1:0] addr_mask;
    addr_mask = (FIFO_EXT_W'(1) << ptr_w) - FIFO_EXT_W'(1);
    return (wr_ptr[ptr_w] != rd_ptr[ptr_w]) && ((wr_ptr & addr_mask) == (rd_ptr & addr_mask));
  endfunction

  // Empty: pointers identical including the wrap bit.
  function automatic logic ptr_empty(input logic [FIFO_EXT_W-1:0] wr_ptr,
                                     input logic [FIFO_EXT_W-1:0] rd_ptr);
    return wr_ptr == rd_ptr;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Enable-gated wrap-around pointer counter with synchronous active-high reset.
// o_nxt exposes the next-state value so the parent can register flags from it.
module fifo_ptr_cnt #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_nxt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next pointer: advance by one on enable, natural modulo 2**WIDTH wrap.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(i_en);
  end

  // Pointer register; reset wins over advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
  // During reset the parent recomputes flags from zero, so no reset gating here.
  assign o_nxt = cnt_d;

endmodule

// File: rtl/sync_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller for a 2**PTR_WIDTH-entry dual-port RAM.
// Owns write/read pointers, registered count, full/empty and almost-full/almost-empty flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined;
// otherwise both outputs are tied low and i_err_clr is ignored.
module sync_fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = FIFO_PTR_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  input  logic [PTR_WIDTH:0] i_af_thresh,
  input  logic [PTR_WIDTH:0] i_ae_thresh,
  input  logic               i_err_clr,
  output logic [PTR_WIDTH-1:0] o_wr_addr,
  output logic [PTR_WIDTH-1:0] o_rd_addr,
  output logic               o_wr_accept,
  output logic               o_rd_accept,
  output logic [PTR_WIDTH:0] o_count,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic               o_overflow,
  output logic               o_underflow
);

  typedef logic [PTR_WIDTH:0] lptr_t;

  localparam logic [3:0] PtrW = 4'(PTR_WIDTH);

  lptr_t wr_ptr, rd_ptr, nxt_wr, nxt_rd, nxt_cnt;

  lptr_t count_q, count_d;
  logic  full_q, full_d;
  logic  empty_q, empty_d;
  logic  afull_q, afull_d;
  logic  aempty_q, aempty_d;

  // Accepts use registered flags only: no pass-through when full or empty.
  always_comb begin
    o_wr_accept = i_wr_en & ~full_q;
    o_rd_accept = i_rd_en & ~empty_q;
  end

  fifo_ptr_cnt #(
    .WIDTH (PTR_WIDTH + 1)
  ) u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (o_wr_accept),
    .o_cnt (wr_ptr),
    .o_nxt (nxt_wr)
  );

  fifo_ptr_cnt #(
    .WIDTH (PTR_WIDTH + 1)
  ) u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (o_rd_accept),
    .o_cnt (rd_ptr),
    .o_nxt (nxt_rd)
  );

  // Flags and count derived from the next pointers so they line up with the pointer update.
  always_comb begin
    nxt_cnt  = nxt_wr - nxt_rd;
    count_d  = nxt_cnt;
    full_d   = ptr_full(FIFO_EXT_W'(nxt_wr), FIFO_EXT_W'(nxt_rd), PtrW);
    empty_d  = ptr_empty(FIFO_EXT_W'(nxt_wr), FIFO_EXT_W'(nxt_rd));
    afull_d  = nxt_cnt >= i_af_thresh;
    aempty_d = nxt_cnt <= i_ae_thresh;
    if (i_rst) begin
      count_d  = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      afull_d  = 1'b0;
      aempty_d = 1'b1;
    end
  end

  // Flag/count registers.
  always_ff @(posedge i_clk) begin
    count_q  <= count_d;
    full_q   <= full_d;
    empty_q  <= empty_d;
    afull_q  <= afull_d;
    aempty_q <= aempty_d;
  end

  assign o_wr_addr      = wr_ptr[PTR_WIDTH-1:0];
  assign o_rd_addr      = rd_ptr[PTR_WIDTH-1:0];
  assign o_count        = count_q;
  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags: a new error event outranks a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (i_err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (i_wr_en && full_q) begin
      ovf_d = 1'b1;
    end
    if (i_rd_en && empty_q) begin
      unf_d = 1'b1;
    end
    if (i_rst) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge i_clk) begin
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ptr_ctrl.sv
// Self-checking bench for sync_fifo_ptr_ctrl at PTR_WIDTH=3 (depth 8).
// Table vectors cover reset/fill/full corners; an independent occupancy model covers the rest.
module tb_sync_fifo_ptr_ctrl;

  localparam int PW    = 3;
  localparam int Depth = 8;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst = 1'b0, i_wr_en = 1'b0, i_rd_en = 1'b0, i_err_clr = 1'b0;
  logic [PW:0]   af_th = 4'd6, ae_th = 4'd1;
  logic [PW-1:0] o_wr_addr, o_rd_addr;
  logic          o_wr_accept, o_rd_accept;
  logic [PW:0]   o_count;
  logic          o_full, o_empty, o_almost_full, o_almost_empty, o_overflow, o_underflow;

  always #5 clk = ~clk;

  sync_fifo_ptr_ctrl #(
    .PTR_WIDTH (PW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_wr_en        (i_wr_en),
    .i_rd_en        (i_rd_en),
    .i_af_thresh    (af_th),
    .i_ae_thresh    (ae_th),
    .i_err_clr      (i_err_clr),
    .o_wr_addr      (o_wr_addr),
    .o_rd_addr      (o_rd_addr),
    .o_wr_accept    (o_wr_accept),
    .o_rd_accept    (o_rd_accept),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  typedef struct {
    int cnt;
    bit full, empty, af, ae, ov, un;
    int waddr, raddr;
  } exp_t;

  typedef struct {
    bit   rst, wr, rd, clr;
    bit   wa, ra;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model state.
  int m_cnt = 0, m_wa = 0, m_ra = 0;
  bit m_ov = 0, m_un = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input bit rst, input bit wr, input bit rd, input bit wa,
                              input bit ra, input int cnt, input bit full, input bit empty,
                              input bit af, input bit ae, input bit ov, input int waddr,
                              input int raddr);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.clr = 1'b0; v.wa = wa; v.ra = ra;
    v.e.cnt = cnt; v.e.full = full; v.e.empty = empty; v.e.af = af; v.e.ae = ae;
    v.e.ov = ov; v.e.un = 1'b0; v.e.waddr = waddr; v.e.raddr = raddr;
    return v;
  endfunction

  // One clock: drive at negedge, check combinational accepts, push the expected registered
  // state, then pop and compare just after the posedge.
  task automatic step(input bit rst, input bit wr, input bit rd, input bit clr,
                      input bit use_tab, input vec_t tv);
    exp_t e, got;
    bit   wacc, racc;
    @(negedge clk);
    i_rst = rst; i_wr_en = wr; i_rd_en = rd; i_err_clr = clr;
    #1;
    wacc = wr && (m_cnt != Depth);
    racc = rd && (m_cnt != 0);
    chk("wr_accept", int'(o_wr_accept), int'(use_tab ? tv.wa : wacc));
    chk("rd_accept", int'(o_rd_accept), int'(use_tab ? tv.ra : racc));
    if (rst) begin
      m_cnt = 0; m_wa = 0; m_ra = 0; m_ov = 0; m_un = 0;
    end else begin
      if (ErrEn) begin
        m_ov = (wr && m_cnt == Depth) ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_un = (rd && m_cnt == 0)     ? 1'b1 : (clr ? 1'b0 : m_un);
      end
      m_cnt = m_cnt + int'(wacc) - int'(racc);
      m_wa  = (m_wa + int'(wacc)) % Depth;
      m_ra  = (m_ra + int'(racc)) % Depth;
    end
    e.cnt   = m_cnt;
    e.full  = (m_cnt == Depth);
    e.empty = (m_cnt == 0);
    e.af    = rst ? 1'b0 : (m_cnt >= int'(af_th));
    e.ae    = rst ? 1'b1 : (m_cnt <= int'(ae_th));
    e.ov    = m_ov;
    e.un    = m_un;
    e.waddr = m_wa;
    e.raddr = m_ra;
    sb_q.push_back(use_tab ? tv.e : e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      got = sb_q.pop_front();
      chk("count",        int'(o_count),        got.cnt);
      chk("full",         int'(o_full),         int'(got.full));
      chk("empty",        int'(o_empty),        int'(got.empty));
      chk("almost_full",  int'(o_almost_full),  int'(got.af));
      chk("almost_empty", int'(o_almost_empty), int'(got.ae));
      chk("overflow",     int'(o_overflow),     int'(got.ov));
      chk("underflow",    int'(o_underflow),    int'(got.un));
      chk("wr_addr",      int'(o_wr_addr),      got.waddr);
      chk("rd_addr",      int'(o_rd_addr),      got.raddr);
    end
  endtask

  task automatic run(input bit rst, input bit wr, input bit rd, input bit clr, input int n);
    vec_t none;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step(rst, wr, rd, clr, 1'b0, none);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tab[12];
    // Reset, idle, eight writes, blocked ninth write, read+write while full.
    tab[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    tab[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tab[1+k] = mk(0, 1, 0, 1, 0, k, k == 8, 0, k >= 6, k <= 1, 0, k % 8, 0);
    end
    tab[10] = mk(0, 1, 0, 0, 0, 8, 1, 0, 1, 0, ErrEn, 0, 0);
    tab[11] = mk(0, 1, 1, 0, 1, 7, 0, 0, 1, 0, ErrEn, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(tab[i].rst, tab[i].wr, tab[i].rd, tab[i].clr, 1'b1, tab[i]);
    end

    run(0, 0, 0, 1, 1);   // clear overflow
    run(0, 0, 1, 0, 3);   // 7 -> 4
    run(0, 1, 1, 0, 20);  // steady at 4 while addresses wrap
    run(0, 0, 1, 0, 4);   // drain to empty
    run(0, 0, 1, 0, 2);   // underflow attempts
    run(0, 0, 0, 0, 1);   // sticky hold
    run(0, 0, 1, 1, 1);   // set beats clear
    run(0, 0, 0, 1, 1);   // clear
    af_th = 4'd0;
    run(0, 0, 0, 0, 1);   // threshold 0: almost_full while empty
    af_th = 4'd6;
    run(0, 1, 0, 0, 5);   // count 5
    run(1, 1, 0, 0, 1);   // reset mid-stream wins over write
    run(0, 0, 0, 0, 1);

    for (int i = 0; i < 80; i++) begin
      if (i % 16 == 0) begin
        af_th = 4'($urandom_range(0, 8));
        ae_th = 4'($urandom_range(0, 8));
      end
      run($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 7) == 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
